// File: rtl/md5_stream_core_if.sv
// Block-transfer and digest bus between the MD5 padder, md5_stream_core and the digest consumer.
interface md5_stream_core_if;
    logic [511:0] blk_i;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic         first_i;
    logic         last_i;
    logic [127:0] digest_o;
    logic         digest_valid_o;
    logic         busy_o;
    logic [31:0]  blk_cnt_o;

    modport slave (
        input  blk_i, blk_valid_i, first_i, last_i,
        output blk_ready_o, digest_o, digest_valid_o, busy_o, blk_cnt_o
    );

    modport master (
        output blk_i, blk_valid_i, first_i, last_i,
        input  blk_ready_o, digest_o, digest_valid_o, busy_o, blk_cnt_o
    );
endinterface

// File: rtl/md5_stream_core.sv
// Multi-block MD5 compression engine evaluating 1, 2 or 4 steps per clock.
// Optional per-message block counter enabled by defining MD5_BLK_CNT_EN.
module md5_stream_core #(
    parameter int STEPS_PER_CLK = 1
) (
    input logic              clk_i,
    input logic              rst_i,
    md5_stream_core_if.slave bus
);

    if (STEPS_PER_CLK != 1 && STEPS_PER_CLK != 2 && STEPS_PER_CLK != 4) begin : g_bad_steps
        $error("md5_stream_core: STEPS_PER_CLK must be 1, 2 or 4");
    end

    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    localparam logic [31:0] K_ROM [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts indexed by {round, step within group of four}.
    localparam logic [4:0] S_ROM [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADD
    } state_t;

    function automatic logic [127:0] md5_step(
        input logic [127:0] st,
        input logic [5:0]   idx,
        input logic [511:0] blk
    );
        logic [31:0] a, b, c, d, f, m, sum, rot;
        logic [7:0]  g_full;
        logic [3:0]  g;
        logic [4:0]  s, rs;
        {a, b, c, d} = st;
        f      = 32'h0;
        g_full = 8'h0;
        case (idx[5:4])
            2'd0: begin
                f      = (b & c) | (~b & d);
                g_full = {2'b00, idx};
            end
            2'd1: begin
                f      = (b & d) | (c & ~d);
                g_full = {2'b00, idx} * 8'd5 + 8'd1;
            end
            2'd2: begin
                f      = b ^ c ^ d;
                g_full = {2'b00, idx} * 8'd3 + 8'd5;
            end
            default: begin
                f      = c ^ (b | ~d);
                g_full = {2'b00, idx} * 8'd7;
            end
        endcase
        g   = g_full[3:0];
        m   = blk[{g, 5'd0} +: 32];
        s   = S_ROM[{idx[5:4], idx[1:0]}];
        rs  = 5'd0 - s;
        sum = a + f + K_ROM[idx] + m;
        rot = (sum << s) | (sum >> rs);
        return {d, b + rot, b, c};
    endfunction

    state_t        state_q, state_d;
    logic [5:0]    step_q, step_d;
    logic [511:0]  blk_q, blk_d;
    logic          last_q, last_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  chain_q, chain_d;
    logic [127:0]  digest_q, digest_d;
    logic          digest_valid_q, digest_valid_d;
    logic [127:0]  round_st;
    logic [127:0]  add_sum;
    logic          accept;

    assign accept = (state_q == IDLE) && bus.blk_valid_i;

    // S step instances chained combinationally from the working registers.
    always_comb begin
        round_st = work_q;
        for (int k = 0; k < STEPS_PER_CLK; k++) begin
            round_st = md5_step(round_st, step_q + 6'(k), blk_q);
        end
    end

    assign add_sum = {chain_q[127:96] + work_q[127:96],
                      chain_q[95:64]  + work_q[95:64],
                      chain_q[63:32]  + work_q[63:32],
                      chain_q[31:0]   + work_q[31:0]};

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        blk_d          = blk_q;
        last_d         = last_q;
        work_d         = work_q;
        chain_d        = chain_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    blk_d   = bus.blk_i;
                    last_d  = bus.last_i;
                    work_d  = bus.first_i ? IV : chain_q;
                    chain_d = bus.first_i ? IV : chain_q;
                    step_d  = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = round_st;
                step_d = step_q + 6'(STEPS_PER_CLK);
                if (step_q == 6'(64 - STEPS_PER_CLK)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                chain_d = add_sum;
                if (last_q) begin
                    digest_d       = add_sum;
                    digest_valid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            step_q         <= 6'd0;
            blk_q          <= '0;
            last_q         <= 1'b0;
            work_q         <= '0;
            chain_q        <= IV;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            blk_q          <= blk_d;
            last_q         <= last_d;
            work_q         <= work_d;
            chain_q        <= chain_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign bus.blk_ready_o    = (state_q == IDLE);
    assign bus.busy_o         = (state_q == RUN) || (state_q == ADD);
    assign bus.digest_o       = digest_q;
    assign bus.digest_valid_o = digest_valid_q;

`ifdef MD5_BLK_CNT_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;

    // A first block restarts the count; later blocks saturate rather than wrap.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (accept) begin
            if (bus.first_i) begin
                blk_cnt_d = 32'd1;
            end else if (blk_cnt_q != 32'hffffffff) begin
                blk_cnt_d = blk_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blk_cnt_q <= 32'd0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign bus.blk_cnt_o = blk_cnt_q;
`else
    assign bus.blk_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_md5_stream_core.sv
// Directed-vector bench for md5_stream_core with one instance per legal STEPS_PER_CLK.
module tb_md5_stream_core;

    localparam logic [127:0] DIG_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] DIG_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [127:0] IV        = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    localparam logic [31:0] K_TAB [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int S_TAB [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    logic         clk;
    logic         rst;
    logic [511:0] blk_r;
    logic         first_r;
    logic         last_r;
    logic [2:0]   valid_v;
    logic [2:0]   ready_v, busy_v, dv_v;
    logic [127:0] dig_v [3];
    logic [31:0]  cnt_v [3];
    int           errors;
    int           checks;

    md5_stream_core_if bus1 ();
    md5_stream_core_if bus2 ();
    md5_stream_core_if bus4 ();

    assign bus1.blk_i = blk_r;  assign bus1.first_i = first_r;  assign bus1.last_i = last_r;
    assign bus2.blk_i = blk_r;  assign bus2.first_i = first_r;  assign bus2.last_i = last_r;
    assign bus4.blk_i = blk_r;  assign bus4.first_i = first_r;  assign bus4.last_i = last_r;
    assign bus1.blk_valid_i = valid_v[0];
    assign bus2.blk_valid_i = valid_v[1];
    assign bus4.blk_valid_i = valid_v[2];

    assign ready_v = {bus4.blk_ready_o, bus2.blk_ready_o, bus1.blk_ready_o};
    assign busy_v  = {bus4.busy_o, bus2.busy_o, bus1.busy_o};
    assign dv_v    = {bus4.digest_valid_o, bus2.digest_valid_o, bus1.digest_valid_o};
    assign dig_v[0] = bus1.digest_o;  assign dig_v[1] = bus2.digest_o;  assign dig_v[2] = bus4.digest_o;
    assign cnt_v[0] = bus1.blk_cnt_o; assign cnt_v[1] = bus2.blk_cnt_o; assign cnt_v[2] = bus4.blk_cnt_o;

    md5_stream_core #(.STEPS_PER_CLK(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    md5_stream_core #(.STEPS_PER_CLK(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
    md5_stream_core #(.STEPS_PER_CLK(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight textbook MD5 compression, used for the multi-block vector.
    function automatic logic [127:0] md5_model(input logic [127:0] chain, input logic [511:0] blk);
        logic [31:0] a, b, c, d, f, t, nb;
        int g, s;
        {a, b, c, d} = chain;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            s  = S_TAB[(i / 16) * 4 + (i % 4)];
            t  = a + f + K_TAB[i] + blk[32 * g +: 32];
            t  = (t << s) | (t >> (32 - s));
            nb = b + t;
            a  = d;
            d  = c;
            c  = b;
            b  = nb;
        end
        return {chain[127:96] + a, chain[95:64] + b, chain[63:32] + c, chain[31:0] + d};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offers one block to instance sel, then follows it until the core is ready again.
    task automatic applyStimulus(input int sel, input logic [511:0] blk, input logic f, input logic l,
                                 input bit corrupt, output int lat, output bit pulsed,
                                 output logic [127:0] dig);
        int n;
        @(negedge clk);
        blk_r = blk;
        first_r = f;
        last_r = l;
        valid_v[sel] = 1'b1;
        n = 0;
        while (!ready_v[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkOutput("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        valid_v[sel] = 1'b0;
        checkOutput("busy_after_accept", busy_v[sel], 1);
        checkOutput("ready_after_accept", ready_v[sel], 0);
        lat = 0;
        pulsed = 1'b0;
        dig = dig_v[sel];
        while (lat < 200) begin
            if (corrupt) begin
                blk_r = {16{$urandom}};
                valid_v[sel] = ~valid_v[sel];
            end
            @(posedge clk);
            lat++;
            #1;
            if (dv_v[sel]) begin
                pulsed = 1'b1;
                dig = dig_v[sel];
            end
            if (ready_v[sel]) break;
        end
        valid_v[sel] = 1'b0;
        if (lat >= 200) checkOutput("done_timeout", 0, 1);
    endtask

    initial begin
        logic [511:0] blk_empty, blk_abc, blk_aaaa, blk_pad64;
        logic [127:0] dig, exp_two, prev_dig;
        int           lat;
        bit           pulsed;
        int           exp_lat [3];

        errors = 0;
        checks = 0;
        exp_lat = '{65, 33, 17};
        blk_empty = '0;
        blk_empty[31:0] = 32'h00000080;
        blk_abc = '0;
        blk_abc[31:0] = 32'h80636261;
        blk_abc[14*32 +: 32] = 32'h00000018;
        blk_aaaa = {16{32'h61616161}};
        blk_pad64 = '0;
        blk_pad64[31:0] = 32'h00000080;
        blk_pad64[14*32 +: 32] = 32'h00000200;

        rst = 1'b1;
        blk_r = '0;
        first_r = 1'b0;
        last_r = 1'b0;
        valid_v = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_ready", ready_v[0], 1);
        checkOutput("reset_busy", busy_v[0], 0);
        checkOutput("reset_dv", dv_v[0], 0);
        checkOutput("reset_digest", dig_v[0], 0);
        checkOutput("reset_cnt", cnt_v[0], 0);

        $display("[TB] empty message, one step per clock");
        applyStimulus(0, blk_empty, 1'b1, 1'b1, 1'b0, lat, pulsed, dig);
        checkOutput("empty_lat", lat, 65);
        checkOutput("empty_pulse", pulsed, 1);
        checkOutput("empty_digest", dig, DIG_EMPTY);

        $display("[TB] abc at each step rate");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(s, blk_abc, 1'b1, 1'b1, 1'b0, lat, pulsed, dig);
            checkOutput($sformatf("abc_lat_%0d", s), lat, exp_lat[s]);
            checkOutput($sformatf("abc_pulse_%0d", s), pulsed, 1);
            checkOutput($sformatf("abc_digest_%0d", s), dig, DIG_ABC);
        end

        $display("[TB] two-block message");
        exp_two = md5_model(md5_model(IV, blk_aaaa), blk_pad64);
        prev_dig = dig_v[1];
        applyStimulus(1, blk_aaaa, 1'b1, 1'b0, 1'b0, lat, pulsed, dig);
        checkOutput("two_blk1_lat", lat, 33);
        checkOutput("two_blk1_nopulse", pulsed, 0);
        checkOutput("two_blk1_digest_held", dig_v[1], prev_dig);
        applyStimulus(1, blk_pad64, 1'b0, 1'b1, 1'b0, lat, pulsed, dig);
        checkOutput("two_blk2_pulse", pulsed, 1);
        checkOutput("two_digest", dig, exp_two);
`ifdef MD5_BLK_CNT_EN
        checkOutput("two_cnt", cnt_v[1], 2);
`else
        checkOutput("two_cnt", cnt_v[1], 0);
`endif

        $display("[TB] back-to-back with valid held");
        @(negedge clk);
        blk_r = blk_abc;
        first_r = 1'b1;
        last_r = 1'b1;
        valid_v[2] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("b2b_first_accept", busy_v[2], 1);
        lat = 0;
        while (lat < 100 && !dv_v[2]) begin
            @(posedge clk);
            lat++;
            #1;
        end
        checkOutput("b2b_lat1", lat, 17);
        checkOutput("b2b_digest1", dig_v[2], DIG_ABC);
        checkOutput("b2b_ready_with_dv", ready_v[2], 1);
        @(posedge clk);
        #1;
        checkOutput("b2b_second_accept", busy_v[2], 1);
        checkOutput("b2b_dv_single", dv_v[2], 0);
        lat = 0;
        while (lat < 100 && !dv_v[2]) begin
            @(posedge clk);
            lat++;
            #1;
        end
        valid_v[2] = 1'b0;
        checkOutput("b2b_lat2", lat, 17);
        checkOutput("b2b_digest2", dig_v[2], DIG_ABC);
`ifdef MD5_BLK_CNT_EN
        checkOutput("b2b_cnt", cnt_v[2], 1);
`else
        checkOutput("b2b_cnt", cnt_v[2], 0);
`endif

        $display("[TB] inputs disturbed while running");
        applyStimulus(1, blk_abc, 1'b1, 1'b1, 1'b1, lat, pulsed, dig);
        checkOutput("corrupt_lat", lat, 33);
        checkOutput("corrupt_digest", dig, DIG_ABC);

        $display("[TB] reset in the middle of a block");
        @(negedge clk);
        blk_r = blk_abc;
        first_r = 1'b1;
        last_r = 1'b1;
        valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        valid_v[0] = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", ready_v[0], 1);
        checkOutput("midrst_busy", busy_v[0], 0);
        checkOutput("midrst_dv", dv_v[0], 0);
        checkOutput("midrst_digest", dig_v[0], 0);
        checkOutput("midrst_cnt", cnt_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, blk_empty, 1'b0, 1'b1, 1'b0, lat, pulsed, dig);
        checkOutput("postrst_lat", lat, 65);
        checkOutput("postrst_digest", dig, DIG_EMPTY);
`ifdef MD5_BLK_CNT_EN
        checkOutput("postrst_cnt", cnt_v[0], 1);
`else
        checkOutput("postrst_cnt", cnt_v[0], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
